// File: rtl/blinker_pkg.sv
// blinker_pkg
// Shared definitions for event_led_blinker: FSM state encoding and
// counter widths.
package blinker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam int TICK_W  = 8;  // tick counter width (phases up to 255 ticks)
    localparam int BLINK_W = 4;  // blink counter width (up to 15 blinks)

endpackage

// File: rtl/event_led_blinker.sv
// event_led_blinker
// Plays a burst of BLINKS LED blinks for each event. Phase lengths are
// counted in tick_en strobes from an external timebase. One event that
// arrives while a burst is running is remembered and replays the burst
// back-to-back when the current one completes.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active high
//   tick_en  in   single-cycle timebase strobe
//   evt_in   in   single-cycle event pulse
//   led_out  out  registered LED drive, high during ON phases
//   busy     out  registered, high while a burst is running
//   done     out  registered one-cycle pulse when a burst completes
module event_led_blinker
    import blinker_pkg::*;
#(
    parameter int ON_TICKS  = 4,
    parameter int OFF_TICKS = 4,
    parameter int BLINKS    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_en,
    input  logic evt_in,
    output logic led_out,
    output logic busy,
    output logic done
);

    localparam logic [TICK_W-1:0]  ON_LIM    = ON_TICKS[TICK_W-1:0];
    localparam logic [TICK_W-1:0]  OFF_LIM   = OFF_TICKS[TICK_W-1:0];
    localparam logic [BLINK_W-1:0] BLINK_LIM = BLINKS[BLINK_W-1:0];

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [BLINK_W-1:0]  blink_q, blink_d;   // blinks finished before the current ON
    logic                pend_q, pend_d;
    logic                led_q, led_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [TICK_W-1:0]   tick_inc;
    logic [BLINK_W-1:0]  blink_inc;

    assign tick_inc  = tick_q + TICK_W'(1);
    assign blink_inc = blink_q + BLINK_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            blink_q <= '0;
            pend_q  <= 1'b0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            blink_q <= blink_d;
            pend_q  <= pend_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        blink_d = blink_q;
        pend_d  = pend_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (evt_in) begin
                    state_d = ST_ON;
                    tick_d  = '0;
                    blink_d = '0;
                end
            end
            ST_ON: begin
                // Set before the completion check so an event landing on the
                // completing cycle still triggers the back-to-back restart.
                if (evt_in) pend_d = 1'b1;
                if (tick_en) begin
                    tick_d = tick_inc;
                    if (tick_inc == ON_LIM) begin
                        tick_d = '0;
                        if (blink_inc < BLINK_LIM) begin
                            state_d = ST_OFF;
                        end else begin
                            done_d  = 1'b1;
                            blink_d = '0;
                            if (pend_q || evt_in) begin
                                state_d = ST_ON;   // LED stays lit, no gap
                                pend_d  = 1'b0;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
            end
            ST_OFF: begin
                if (evt_in) pend_d = 1'b1;
                if (tick_en) begin
                    tick_d = tick_inc;
                    if (tick_inc == OFF_LIM) begin
                        tick_d  = '0;
                        blink_d = blink_inc;
                        state_d = ST_ON;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tick_d  = '0;
                blink_d = '0;
                pend_d  = 1'b0;
            end
        endcase

        // Outputs registered from the next state so they line up with it.
        led_d  = (state_d == ST_ON);
        busy_d = (state_d != ST_IDLE);
    end

    assign led_out = led_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_event_led_blinker.sv
// tb_event_led_blinker
// Directed stimulus with an expectation queue: each driven cycle pushes the
// outputs expected after the next clock edge; a negedge monitor pops and
// compares. Per-scenario done-pulse and LED-rise counts are checked against
// hand-derived totals.
module tb_event_led_blinker;

    localparam int ON_T  = 2;
    localparam int OFF_T = 3;
    localparam int BL    = 2;

    logic clk = 1'b0;
    logic rst, tick_en, evt_in;
    logic led_out, busy, done;

    event_led_blinker #(
        .ON_TICKS (ON_T),
        .OFF_TICKS(OFF_T),
        .BLINKS   (BL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .tick_en(tick_en),
        .evt_in (evt_in),
        .led_out(led_out),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic led;
        logic busy;
        logic done;
    } exp_t;

    exp_t sb[$];

    int   n_chk = 0;
    int   n_pass = 0;
    int   done_seen = 0;
    int   rises = 0;
    logic led_prev = 1'b0;

    // Reference behaviour state
    int m_st = 0;     // 0 idle, 1 on, 2 off
    int m_cnt = 0;
    int m_blk = 0;    // blinks completed in the running burst
    bit m_pend = 0;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done === 1'b1) done_seen++;
            if (led_out === 1'b1 && led_prev !== 1'b1) rises++;
        end
        led_prev = led_out;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk_b($sformatf("led@%0d", e.cyc),  led_out, e.led);
            chk_b($sformatf("busy@%0d", e.cyc), busy,    e.busy);
            chk_b($sformatf("done@%0d", e.cyc), done,    e.done);
        end
    end

    task automatic model_step(input bit t, input bit e, output exp_t x);
        bit dn;
        dn = 1'b0;
        case (m_st)
            0: if (e) begin m_st = 1; m_cnt = 0; m_blk = 0; end
            1: begin
                if (e) m_pend = 1'b1;
                if (t) begin
                    m_cnt++;
                    if (m_cnt == ON_T) begin
                        m_cnt = 0;
                        m_blk++;
                        if (m_blk < BL) m_st = 2;
                        else begin
                            dn = 1'b1;
                            m_blk = 0;
                            if (m_pend) begin m_pend = 1'b0; m_st = 1; end
                            else m_st = 0;
                        end
                    end
                end
            end
            2: begin
                if (e) m_pend = 1'b1;
                if (t) begin
                    m_cnt++;
                    if (m_cnt == OFF_T) begin m_cnt = 0; m_st = 1; end
                end
            end
            default: ;
        endcase
        x.cyc  = cyc + 1;
        x.led  = (m_st == 1);
        x.busy = (m_st != 0);
        x.done = dn;
    endtask

    task automatic step(input bit t, input bit e);
        exp_t x;
        tick_en = t;
        evt_in  = e;
        model_step(t, e, x);
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // per = 0: no ticks; otherwise a tick on every per-th step.
    task automatic run(input int n, input int per, input int ev[4]);
        for (int i = 0; i < n; i++) begin
            bit e;
            bit t;
            e = 1'b0;
            for (int k = 0; k < 4; k++) if (ev[k] == i) e = 1'b1;
            t = (per != 0) && (i % per == per - 1);
            step(t, e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        tick_en = 1'b0;
        evt_in = 1'b0;
        #1;
        chk_b("async_rst_led",  led_out, 1'b0);
        chk_b("async_rst_busy", busy,    1'b0);
        chk_b("async_rst_done", done,    1'b0);
        m_st = 0; m_cnt = 0; m_blk = 0; m_pend = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick_en = 1'b0;
        evt_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_b("reset_led",  led_out, 1'b0);
        chk_b("reset_busy", busy,    1'b0);
        chk_b("reset_done", done,    1'b0);
        rst = 1'b0;

        // Single event, tick every 4th cycle: two blinks, one done
        done_seen = 0; rises = 0;
        run(60, 4, '{10, -1, -1, -1});
        chk_i("t1_done_cnt", done_seen, 1);
        chk_i("t1_led_rises", rises, 2);
        chk_b("t1_idle_busy", busy, 1'b0);

        // tick held high: each phase exactly ON_T / OFF_T cycles
        done_seen = 0; rises = 0;
        run(30, 1, '{5, -1, -1, -1});
        chk_i("t2_done_cnt", done_seen, 1);
        chk_i("t2_led_rises", rises, 2);

        // Three events during the first OFF collapse into one restart
        done_seen = 0; rises = 0;
        run(90, 4, '{10, 18, 20, 22});
        chk_i("t3_done_cnt", done_seen, 2);
        chk_i("t3_led_rises", rises, 3);
        chk_b("t3_idle_busy", busy, 1'b0);

        // Event on the completion cycle restarts with no LED gap
        done_seen = 0; rises = 0;
        run(40, 1, '{5, 12, -1, -1});
        chk_i("t4_done_cnt", done_seen, 2);
        chk_i("t4_led_rises", rises, 3);

        // Reset during the second ON phase aborts without done
        done_seen = 0; rises = 0;
        run(12, 1, '{5, -1, -1, -1});
        chk_b("t5_in_second_on", led_out, 1'b1);
        do_reset();
        chk_i("t5_no_done", done_seen, 0);
        done_seen = 0; rises = 0;
        run(30, 1, '{3, -1, -1, -1});
        chk_i("t5_post_done_cnt", done_seen, 1);
        chk_i("t5_post_led_rises", rises, 2);

        // No ticks: LED holds in ON indefinitely
        done_seen = 0; rises = 0;
        run(100, 0, '{2, -1, -1, -1});
        chk_b("t6_led_held",  led_out, 1'b1);
        chk_b("t6_busy_held", busy,    1'b1);
        chk_i("t6_no_done", done_seen, 0);
        chk_i("t6_led_rises", rises, 1);
        do_reset();

        @(negedge clk);
        #1;
        chk_i("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
